// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a main slot and a skid slot.
// All outputs come straight from flops, so in_ready has no combinational path from out_ready.
module pipe_stage_elastic #(
  parameter int                DATA_W      = 106,
  parameter int                CTRL_W      = 4,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                CLEAR_DATA  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  state_t w_next;
  logic   w_accept;
  logic   w_drain;
  logic   w_load_main_in;
  logic   w_load_main_skid;
  logic   w_load_skid;
  logic   w_to_empty;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = (r_state != S_EMPTY) & out_ready;

  // Next-state and slot-load decisions; flush overrides every handshake.
  always_comb begin
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_to_empty       = 1'b0;
    if (flush) begin
      w_next     = S_EMPTY;
      w_to_empty = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_next         = S_ONE;
            w_load_main_in = 1'b1;
          end else begin
            w_next = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_next      = S_TWO;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_next     = S_EMPTY;
            w_to_empty = 1'b1;
          end else begin
            w_next = S_ONE;
          end
        end
        S_TWO: begin
          if (w_drain) begin
            w_next           = S_ONE;
            w_load_main_skid = 1'b1;
          end else begin
            w_next = S_TWO;
          end
        end
        default: begin
          w_next     = S_EMPTY;
          w_to_empty = 1'b1;
        end
      endcase
    end
  end

  // State and registered in_ready (low throughout reset, rises on the first edge after).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
    end
  end

  // Main slot; ctrl parks at the bubble code whenever the stage empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_ctrl <= BUBBLE_CTRL;
      r_main_data <= '0;
    end else if (w_to_empty) begin
      r_main_ctrl <= BUBBLE_CTRL;
      if (CLEAR_DATA) begin
        r_main_data <= '0;
      end else begin
        r_main_data <= r_main_data;
      end
    end else if (w_load_main_in) begin
      r_main_ctrl <= in_ctrl;
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_ctrl <= r_skid_ctrl;
      r_main_data <= r_skid_data;
    end else begin
      r_main_ctrl <= r_main_ctrl;
      r_main_data <= r_main_data;
    end
  end

  // Skid slot, only written when the main slot is stalled and a new entry arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_ctrl <= BUBBLE_CTRL;
      r_skid_data <= '0;
    end else if (flush) begin
      r_skid_ctrl <= BUBBLE_CTRL;
      if (CLEAR_DATA) begin
        r_skid_data <= '0;
      end else begin
        r_skid_data <= r_skid_data;
      end
    end else if (w_load_skid) begin
      r_skid_ctrl <= in_ctrl;
      r_skid_data <= in_data;
    end else begin
      r_skid_ctrl <= r_skid_ctrl;
      r_skid_data <= r_skid_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

endmodule
